// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM pipeline register bus: EX-side inputs, stage controls and MEM-side outputs.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WB_W       = 2,
  parameter int unsigned CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  EX_valid;
  logic [WB_W-1:0]       EX_wb;
  logic [2:0]            EX_m;
  logic [DATA_W-1:0]     EX_branch_target;
  logic                  EX_zero;
  logic [DATA_W-1:0]     EX_alu_result;
  logic [DATA_W-1:0]     EX_reg_data2;
  logic [REG_ADDR_W-1:0] EX_reg_dst_mux_out;

  logic                  MEM_valid;
  logic [WB_W-1:0]       MEM_wb;
  logic                  MEM_branch;
  logic                  MEM_mem_read;
  logic                  MEM_mem_write;
  logic [DATA_W-1:0]     MEM_branch_target;
  logic                  MEM_zero;
  logic [DATA_W-1:0]     MEM_alu_result;
  logic [DATA_W-1:0]     MEM_reg_data2;
  logic [REG_ADDR_W-1:0] MEM_reg_dst_mux_out;
  logic                  MEM_pc_src;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output stall, flush, EX_valid, EX_wb, EX_m, EX_branch_target, EX_zero,
           EX_alu_result, EX_reg_data2, EX_reg_dst_mux_out,
    input  MEM_valid, MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write,
           MEM_branch_target, MEM_zero, MEM_alu_result, MEM_reg_data2,
           MEM_reg_dst_mux_out, MEM_pc_src, bubble_count
  );

  modport slave (
    input  stall, flush, EX_valid, EX_wb, EX_m, EX_branch_target, EX_zero,
           EX_alu_result, EX_reg_data2, EX_reg_dst_mux_out,
    output MEM_valid, MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write,
           MEM_branch_target, MEM_zero, MEM_alu_result, MEM_reg_data2,
           MEM_reg_dst_mux_out, MEM_pc_src, bubble_count
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// Parametrised EX/MEM pipeline register: DEPTH retiming stages with valid,
// stall/flush, registered branch-taken decode and a saturating bubble counter.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WB_W       = 2,
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               startin,
  ex_mem_pipe_reg_if.slave   bus
);

  typedef struct packed {
    logic                  valid;
    logic [WB_W-1:0]       wb;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     branch_target;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     reg_data2;
    logic [REG_ADDR_W-1:0] reg_dst;
  } stage_t;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("ex_mem_pipe_reg: DEPTH must be in 1..4");
    end
  endgenerate

  stage_t           stg [DEPTH];
  stage_t           ex_in;
  logic [CNT_W-1:0] bubbles;

  // Bubbles enter with all controls forced low so no side effect can leak.
  always_comb begin
    ex_in               = '0;
    ex_in.valid         = bus.EX_valid;
    ex_in.branch_target = bus.EX_branch_target;
    ex_in.zero          = bus.EX_zero;
    ex_in.alu_result    = bus.EX_alu_result;
    ex_in.reg_data2     = bus.EX_reg_data2;
    ex_in.reg_dst       = bus.EX_reg_dst_mux_out;
    if (bus.EX_valid) begin
      ex_in.wb        = bus.EX_wb;
      ex_in.branch    = bus.EX_m[2];
      ex_in.mem_read  = bus.EX_m[1];
      ex_in.mem_write = bus.EX_m[0];
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stg[i].valid     <= 1'b0;
        stg[i].wb        <= '0;
        stg[i].branch    <= 1'b0;
        stg[i].mem_read  <= 1'b0;
        stg[i].mem_write <= 1'b0;
      end
    end else if (!bus.stall) begin
      stg[0] <= ex_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  // Counts on flush cycles too: only stall or reset stop it.
  always_ff @(posedge clk) begin
    if (startin) begin
      bubbles <= '0;
    end else if (!bus.stall && !stg[DEPTH-1].valid && bubbles != '1) begin
      bubbles <= bubbles + 1'b1;
    end
  end

  assign bus.MEM_valid           = stg[DEPTH-1].valid;
  assign bus.MEM_wb              = stg[DEPTH-1].wb;
  assign bus.MEM_branch          = stg[DEPTH-1].branch;
  assign bus.MEM_mem_read        = stg[DEPTH-1].mem_read;
  assign bus.MEM_mem_write       = stg[DEPTH-1].mem_write;
  assign bus.MEM_branch_target   = stg[DEPTH-1].branch_target;
  assign bus.MEM_zero            = stg[DEPTH-1].zero;
  assign bus.MEM_alu_result      = stg[DEPTH-1].alu_result;
  assign bus.MEM_reg_data2       = stg[DEPTH-1].reg_data2;
  assign bus.MEM_reg_dst_mux_out = stg[DEPTH-1].reg_dst;
  assign bus.MEM_pc_src          = stg[DEPTH-1].valid & stg[DEPTH-1].branch & stg[DEPTH-1].zero;
  assign bus.bubble_count        = bubbles;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: a DEPTH=1 and a DEPTH=3/CNT_W=4 instance share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        startin, stall, flush, ex_valid, ex_zero;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [31:0] ex_bt, ex_alu, ex_rd2;
  logic [4:0]  ex_dst;

  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .CNT_W(16)) i1 ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .CNT_W(4))  i3 ();

  assign i1.stall = stall;              assign i3.stall = stall;
  assign i1.flush = flush;              assign i3.flush = flush;
  assign i1.EX_valid = ex_valid;        assign i3.EX_valid = ex_valid;
  assign i1.EX_wb = ex_wb;              assign i3.EX_wb = ex_wb;
  assign i1.EX_m = ex_m;                assign i3.EX_m = ex_m;
  assign i1.EX_branch_target = ex_bt;   assign i3.EX_branch_target = ex_bt;
  assign i1.EX_zero = ex_zero;          assign i3.EX_zero = ex_zero;
  assign i1.EX_alu_result = ex_alu;     assign i3.EX_alu_result = ex_alu;
  assign i1.EX_reg_data2 = ex_rd2;      assign i3.EX_reg_data2 = ex_rd2;
  assign i1.EX_reg_dst_mux_out = ex_dst; assign i3.EX_reg_dst_mux_out = ex_dst;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .DEPTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .startin(startin), .bus(i1)
  );
  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .DEPTH(3), .CNT_W(4)) dut3 (
    .clk(clk), .startin(startin), .bus(i3)
  );

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] bt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } ent_t;

  // Reference: per instance, a queue of in-flight entries (front = newest, back = MEM).
  ent_t        mq [2][$];
  int unsigned dep  [2] = '{1, 3};
  int unsigned cmax [2] = '{65535, 15};
  int unsigned cnt  [2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset_all();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      for (int unsigned k = 0; k < dep[d]; k++) mq[d].push_back('0);
      cnt[d] = 0;
    end
  endfunction

  function automatic void model_step();
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      if (startin) begin
        mq[d].delete();
        for (int unsigned k = 0; k < dep[d]; k++) mq[d].push_back('0);
        cnt[d] = 0;
      end else begin
        if (!stall && !mq[d][$].valid && cnt[d] < cmax[d]) cnt[d]++;
        if (flush) begin
          for (int k = 0; k < mq[d].size(); k++) begin
            e = mq[d][k];
            e.valid = 1'b0; e.wb = '0; e.m = '0;
            mq[d][k] = e;
          end
        end else if (!stall) begin
          e.valid = ex_valid;
          e.wb    = ex_valid ? ex_wb : 2'b00;
          e.m     = ex_valid ? ex_m  : 3'b000;
          e.bt = ex_bt; e.zero = ex_zero; e.alu = ex_alu; e.rd2 = ex_rd2; e.dst = ex_dst;
          mq[d].push_front(e);
          void'(mq[d].pop_back());
        end
      end
    end
  endfunction

  task automatic compare_all();
    ent_t o, x;
    logic pc;
    logic [15:0] bc;
    string p;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        p = "D1";
        o.valid = i1.MEM_valid; o.wb = i1.MEM_wb;
        o.m = {i1.MEM_branch, i1.MEM_mem_read, i1.MEM_mem_write};
        o.bt = i1.MEM_branch_target; o.zero = i1.MEM_zero; o.alu = i1.MEM_alu_result;
        o.rd2 = i1.MEM_reg_data2; o.dst = i1.MEM_reg_dst_mux_out;
        pc = i1.MEM_pc_src; bc = i1.bubble_count;
      end else begin
        p = "D3";
        o.valid = i3.MEM_valid; o.wb = i3.MEM_wb;
        o.m = {i3.MEM_branch, i3.MEM_mem_read, i3.MEM_mem_write};
        o.bt = i3.MEM_branch_target; o.zero = i3.MEM_zero; o.alu = i3.MEM_alu_result;
        o.rd2 = i3.MEM_reg_data2; o.dst = i3.MEM_reg_dst_mux_out;
        pc = i3.MEM_pc_src; bc = 16'(i3.bubble_count);
      end
      x = mq[d][$];
      check({p, ".valid"}, 64'(o.valid), 64'(x.valid));
      check({p, ".wb"},    64'(o.wb),    64'(x.wb));
      check({p, ".m"},     64'(o.m),     64'(x.m));
      check({p, ".bt"},    64'(o.bt),    64'(x.bt));
      check({p, ".zero"},  64'(o.zero),  64'(x.zero));
      check({p, ".alu"},   64'(o.alu),   64'(x.alu));
      check({p, ".rd2"},   64'(o.rd2),   64'(x.rd2));
      check({p, ".dst"},   64'(o.dst),   64'(x.dst));
      check({p, ".pc_src"}, 64'(pc), 64'(x.valid & x.m[2] & x.zero));
      check({p, ".bubbles"}, 64'(bc), 64'(cnt[d]));
    end
  endtask

  task automatic cyc(input logic s, input logic st, input logic fl, input logic v,
                     input logic [1:0] wb, input logic [2:0] m, input logic [31:0] bt,
                     input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                     input logic [4:0] dst);
    startin = s; stall = st; flush = fl; ex_valid = v; ex_wb = wb; ex_m = m;
    ex_bt = bt; ex_zero = z; ex_alu = alu; ex_rd2 = rd2; ex_dst = dst;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic cyc_rand(input logic s, input logic st, input logic fl);
    cyc(s, st, fl, 1'($urandom), 2'($urandom), 3'($urandom), $urandom, 1'($urandom),
        $urandom, $urandom, 5'($urandom));
  endtask

  initial begin
    model_reset_all();

    // Reset with busy EX inputs.
    cyc(1, 0, 0, 1, 2'b11, 3'b111, 32'hFFFF_FFFF, 1, 32'h1234, 32'h5678, 5'd31);
    cyc(1, 0, 0, 1, 2'b11, 3'b111, 32'hFFFF_FFFF, 1, 32'h1234, 32'h5678, 5'd31);
    check("rst.valid",   64'(i1.MEM_valid), 64'd0);
    check("rst.pc_src",  64'(i1.MEM_pc_src), 64'd0);
    check("rst.bubbles", 64'(i1.bubble_count), 64'd0);
    check("rst.alu",     64'(i1.MEM_alu_result), 64'd0);

    // Passthrough at DEPTH=1.
    cyc(0, 0, 0, 1, 2'b11, 3'b010, 32'h0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 5'd9);
    check("pass.valid", 64'(i1.MEM_valid), 64'd1);
    check("pass.rd",    64'(i1.MEM_mem_read), 64'd1);
    check("pass.wb",    64'(i1.MEM_wb), 64'd3);
    check("pass.alu",   64'(i1.MEM_alu_result), 64'h1000);
    check("pass.rd2",   64'(i1.MEM_reg_data2), 64'hDEAD_BEEF);
    check("pass.dst",   64'(i1.MEM_reg_dst_mux_out), 64'd9);

    // Branch decode, taken then not taken.
    cyc(0, 0, 0, 1, 2'b00, 3'b100, 32'h0000_0040, 1, 32'h0, 32'h0, 5'd0);
    check("br.taken",  64'(i1.MEM_pc_src), 64'd1);
    check("br.target", 64'(i1.MEM_branch_target), 64'h40);
    cyc(0, 0, 0, 1, 2'b00, 3'b100, 32'h0000_0040, 0, 32'h0, 32'h0, 5'd0);
    check("br.nottaken", 64'(i1.MEM_pc_src), 64'd0);

    // Stall holds everything; flush wins over stall and keeps data.
    cyc(0, 0, 0, 1, 2'b11, 3'b010, 32'h0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      cyc_rand(0, 1, 0);
      check("stall.alu",     64'(i1.MEM_alu_result), 64'h1000);
      check("stall.valid",   64'(i1.MEM_valid), 64'd1);
      check("stall.bubbles", 64'(i1.bubble_count), 64'd1);
    end
    cyc_rand(0, 1, 1);
    check("flush.valid", 64'(i1.MEM_valid), 64'd0);
    check("flush.wb",    64'(i1.MEM_wb), 64'd0);
    check("flush.rd",    64'(i1.MEM_mem_read), 64'd0);
    check("flush.alu",   64'(i1.MEM_alu_result), 64'h1000);

    // DEPTH=3 ordering and latency with one stall after B.
    cyc(1, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0);
    cyc(0, 0, 0, 1, 2'b01, 3'b000, 32'h0, 0, 32'd1, 32'h0, 5'd1);
    cyc(0, 0, 0, 1, 2'b01, 3'b000, 32'h0, 0, 32'd2, 32'h0, 5'd2);
    cyc_rand(0, 1, 0);
    cyc(0, 0, 0, 1, 2'b01, 3'b000, 32'h0, 0, 32'd3, 32'h0, 5'd3);
    for (int i = 1; i <= 3; i++) begin
      check("d3.order.valid", 64'(i3.MEM_valid), 64'd1);
      check("d3.order.alu",   64'(i3.MEM_alu_result), 64'(i));
      cyc(0, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0);
    end

    // Bubble counter saturation at CNT_W=4.
    cyc(1, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0);
    repeat (20) cyc(0, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0);
    check("sat.d3", 64'(i3.bubble_count), 64'd15);
    check("sat.d1", 64'(i1.bubble_count), 64'd20);
    cyc_rand(1, 0, 0);
    check("sat.clear", 64'(i3.bubble_count), 64'd0);

    // Randomized traffic with occasional reset, flush and stall.
    for (int i = 0; i < 400; i++) begin
      cyc_rand(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 20),
               1'($urandom_range(0, 99) < 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
